// File: rtl/dm_responder_pkg.sv
// Shared constants for the data-memory responder: opcodes, funct3 load kinds,
// unshifted store masks and the store legality rule.
package dm_responder_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        F3_BYTE = 3'b000,
        F3_HALF = 3'b001,
        F3_WORD = 3'b010,
        F3_BU   = 3'b100,
        F3_HU   = 3'b101
    } f3_e;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // A store is legal only when its natural alignment holds at the byte offset.
    function automatic logic store_legal(input logic [3:0] mask, input logic [1:0] off);
        case (mask)
            MASK_B:  return 1'b1;
            MASK_H:  return !off[0];
            MASK_W:  return off == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// M-stage request and W-stage load-return signals between pipeline and responder.
interface dm_responder_if;
    logic [3:0]  M_dm_w_en;
    logic        M_ld_en;
    logic [31:0] M_addr;
    logic [31:0] M_wdata;
    logic [2:0]  W_f3;
    logic [31:0] W_ld_data;

    modport master (output M_dm_w_en, M_ld_en, M_addr, M_wdata, W_f3, input W_ld_data);
    modport slave  (input M_dm_w_en, M_ld_en, M_addr, M_wdata, W_f3, output W_ld_data);
endinterface

// File: rtl/dm_responder_ld_extend.sv
// W-stage load formatting: lane select, sign/zero extension and misalignment detect.
module dm_responder_ld_extend
    import dm_responder_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  off,
    input  logic [2:0]  f3,
    input  logic        ld_vld,
    output logic [31:0] data,
    output logic        mis
);

    logic [31:0] sh;
    logic [15:0] unused_sh_hi;

    assign sh           = rd_word >> {off, 3'b000};
    assign unused_sh_hi = sh[31:16];

    always_comb begin
        mis = ld_vld && ((((f3 == F3_HALF) || (f3 == F3_HU)) && off[0]) ||
                         ((f3 == F3_WORD) && (off != 2'b00)));
        data = '0;
        case (f3)
            F3_BYTE: data = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   data = {24'h0, sh[7:0]};
            F3_HALF: data = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   data = {16'h0, sh[15:0]};
            F3_WORD: data = rd_word;
            default: data = '0;
        endcase
        // A misaligned load in W returns zero instead of a partial word.
        if (mis) data = '0;
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: byte-lane synchronous RAM, one-cycle load return,
// sticky misalignment status and saturating access counters.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    dm_responder_if.slave    bus,
    output logic             misalign_err,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [3:0][7:0] mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic              st_req, st_ok, ld_req, w_mis, unused_addr_hi;
    logic [3:0]        lane_mask;
    logic [3:0][7:0]   wdata_sh;
    logic [31:0]       rd_word_q;
    logic [1:0]        off_q;
    logic              ld_q;

    assign idx            = bus.M_addr[ADDR_W+1:2];
    assign off            = bus.M_addr[1:0];
    assign unused_addr_hi = ^bus.M_addr[31:ADDR_W+2];

    assign st_req    = |bus.M_dm_w_en;
    assign st_ok     = st_req && store_legal(bus.M_dm_w_en, off);
    assign ld_req    = bus.M_ld_en && !st_req;
    assign lane_mask = bus.M_dm_w_en << off;
    assign wdata_sh  = bus.M_wdata << {off, 3'b000};

    // RAM contents survive reset; only the write itself is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && st_ok) begin
            for (int i = 0; i < 4; i++)
                if (lane_mask[i]) mem[idx][i] <= wdata_sh[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_word_q    <= '0;
            off_q        <= '0;
            ld_q         <= 1'b0;
            misalign_err <= 1'b0;
            ld_cnt       <= '0;
            st_cnt       <= '0;
        end else begin
            ld_q <= ld_req;
            if (ld_req) begin
                rd_word_q <= mem[idx];
                off_q     <= off;
                if (ld_cnt != '1) ld_cnt <= ld_cnt + CNT_W'(1);
            end
            if (st_ok && st_cnt != '1) st_cnt <= st_cnt + CNT_W'(1);
            // Illegal store, load+store collision, or misaligned load in W.
            if ((st_req && (!st_ok || bus.M_ld_en)) || w_mis) misalign_err <= 1'b1;
        end
    end

    dm_responder_ld_extend u_ld_extend (
        .rd_word (rd_word_q),
        .off     (off_q),
        .f3      (bus.W_f3),
        .ld_vld  (ld_q),
        .data    (bus.W_ld_data),
        .mis     (w_mis)
    );

endmodule
